// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and default constants for the game core
//
// Purpose : FSM state type, coordinate width and the geometry / physics /
//           pacing defaults used as parameter defaults by game_core.
// Ports   : none (package).
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam int COORD_W = 12;

   localparam int DEF_NUM_OBS      = 3;
   localparam int DEF_DINO_X       = 64;
   localparam int DEF_DINO_HALF_W  = 16;
   localparam int DEF_OBS_HALF_W   = 8;
   localparam int DEF_OBS_H        = 40;
   localparam int DEF_SPAWN_X      = 640;
   localparam int DEF_MIN_GAP      = 40;
   localparam int DEF_GAP_MASK     = 63;
   localparam int DEF_JUMP_V       = 12;
   localparam int DEF_GRAVITY      = 1;
   localparam int DEF_SPEED_INIT   = 4;
   localparam int DEF_SPEED_MAX    = 12;
   localparam int DEF_SPEED_STEP   = 500;
   localparam int DEF_NIGHT_PERIOD = 700;
   localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/game_core_if.sv
// rtl/game_core_if.sv - player controls and game state bundle
//
// Purpose : groups the player inputs and the game state outputs of game_core.
// Signals : jump, start                     - player requests (master -> slave)
//           dino_y, obstacle_x,
//           obstacle_valid, night,
//           game_over, score, speed         - game state (slave -> master)
// Modports: master (player / display side), slave (game_core).
interface game_core_if #(
   parameter int COORD_W = 12,
   parameter int NUM_OBS = 3
);

   logic                         jump;
   logic                         start;
   logic [COORD_W-1:0]           dino_y;
   logic [NUM_OBS*COORD_W-1:0]   obstacle_x;
   logic [NUM_OBS-1:0]           obstacle_valid;
   logic                         night;
   logic                         game_over;
   logic [15:0]                  score;
   logic [COORD_W-1:0]           speed;

   modport master (
      output jump, start,
      input  dino_y, obstacle_x, obstacle_valid, night, game_over, score, speed
   );

   modport slave (
      input  jump, start,
      output dino_y, obstacle_x, obstacle_valid, night, game_over, score, speed
   );

endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR, taps 16,14,13,11
//
// Purpose : free-running pseudo-random source for obstacle spacing.
// Ports   : clk  - tick clock
//           rst  - asynchronous active-high reset, loads seed
//           seed - reset value (must be nonzero)
//           out  - current register value
module lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] out
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign out = lfsr_q;

endmodule

// File: rtl/game_core.sv
// rtl/game_core.sv - endless-runner game state machine, physics and obstacles
//
// Purpose : one update per game tick: dino jump physics, obstacle scroll and
//           spawn, collision, score / speed / day-night pacing.
// Ports   : game_clk - game tick clock
//           rst      - asynchronous active-high reset
//           bus      - game_core_if.slave (jump/start in, game state out)
module game_core #(
   parameter int          COORD_W      = game_pkg::COORD_W,
   parameter int          NUM_OBS      = game_pkg::DEF_NUM_OBS,
   parameter int          DINO_X       = game_pkg::DEF_DINO_X,
   parameter int          DINO_HALF_W  = game_pkg::DEF_DINO_HALF_W,
   parameter int          OBS_HALF_W   = game_pkg::DEF_OBS_HALF_W,
   parameter int          OBS_H        = game_pkg::DEF_OBS_H,
   parameter int          SPAWN_X      = game_pkg::DEF_SPAWN_X,
   parameter int          MIN_GAP      = game_pkg::DEF_MIN_GAP,
   parameter int          GAP_MASK     = game_pkg::DEF_GAP_MASK,
   parameter int          JUMP_V       = game_pkg::DEF_JUMP_V,
   parameter int          GRAVITY      = game_pkg::DEF_GRAVITY,
   parameter int          SPEED_INIT   = game_pkg::DEF_SPEED_INIT,
   parameter int          SPEED_MAX    = game_pkg::DEF_SPEED_MAX,
   parameter int          SPEED_STEP   = game_pkg::DEF_SPEED_STEP,
   parameter int          NIGHT_PERIOD = game_pkg::DEF_NIGHT_PERIOD,
   parameter logic [15:0] LFSR_SEED    = game_pkg::DEF_LFSR_SEED
) (
   input  logic        game_clk,
   input  logic        rst,
   game_core_if.slave  bus
);

   import game_pkg::*;

   localparam int CNT_W = 16;
   localparam int VW    = COORD_W + 1;   // signed velocity width
   localparam int SW    = COORD_W + 2;   // signed width for position arithmetic

   typedef logic [COORD_W-1:0] coord_t;

   localparam coord_t                SPAWN_X_C    = COORD_W'(SPAWN_X);
   localparam coord_t                OBS_H_C      = COORD_W'(OBS_H);
   localparam coord_t                JUMP_V_C     = COORD_W'(JUMP_V);
   localparam coord_t                SPEED_INIT_C = COORD_W'(SPEED_INIT);
   localparam coord_t                SPEED_MAX_C  = COORD_W'(SPEED_MAX);
   localparam logic signed [VW-1:0]  VEL0_S       = VW'(JUMP_V - GRAVITY);
   localparam logic signed [VW-1:0]  GRAV_S       = VW'(GRAVITY);
   localparam logic signed [SW-1:0]  DINO_X_S     = SW'(DINO_X);
   localparam logic signed [SW-1:0]  HIT_S        = SW'(DINO_HALF_W + OBS_HALF_W);
   localparam logic [CNT_W-1:0]      MIN_GAP_C    = CNT_W'(MIN_GAP);
   localparam logic [CNT_W-1:0]      GAP_MASK_C   = CNT_W'(GAP_MASK);
   localparam logic [CNT_W-1:0]      SPEED_STEP_C = CNT_W'(SPEED_STEP);
   localparam logic [CNT_W-1:0]      NIGHT_PER_C  = CNT_W'(NIGHT_PERIOD);

   state_t                state_q, state_d;
   coord_t                dino_y_q, dino_y_d;
   logic signed [VW-1:0]  vel_q, vel_d;
   coord_t                obs_x_q [NUM_OBS];
   coord_t                obs_x_d [NUM_OBS];
   logic [NUM_OBS-1:0]    obs_v_q, obs_v_d;
   logic [CNT_W-1:0]      spawn_cnt_q, spawn_cnt_d;
   logic [CNT_W-1:0]      speed_cnt_q, speed_cnt_d;
   logic [CNT_W-1:0]      night_cnt_q, night_cnt_d;
   logic [15:0]           score_q, score_d;
   coord_t                speed_q, speed_d;
   logic                  night_q, night_d;

   logic [15:0]           lfsr;
   logic                  collide;
   logic signed [SW-1:0]  dx;
   logic signed [SW-1:0]  y_sum;
   logic [NUM_OBS-1:0]    free_mask;
   logic                  free_taken;

   lfsr16 u_lfsr (
      .clk  (game_clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .out  (lfsr)
   );

   // Collision looks only at registered state, so the colliding frame is the
   // one that gets frozen on screen.
   always_comb begin
      collide = 1'b0;
      dx      = '0;
      for (int i = 0; i < NUM_OBS; i++) begin
         if (obs_v_q[i] && (dino_y_q < OBS_H_C)) begin
            dx = $signed({2'b00, obs_x_q[i]}) - DINO_X_S;
            if (dx[SW-1]) begin
               dx = -dx;
            end
            if (dx < HIT_S) begin
               collide = 1'b1;
            end
         end
      end
   end

   // Lowest-index slot that was already invalid at the start of this tick; a
   // slot being cleared this tick is not eligible until the next one.
   always_comb begin
      free_mask  = '0;
      free_taken = 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
         if (!obs_v_q[i] && !free_taken) begin
            free_mask[i] = 1'b1;
            free_taken   = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      dino_y_d    = dino_y_q;
      vel_d       = vel_q;
      obs_x_d     = obs_x_q;
      obs_v_d     = obs_v_q;
      spawn_cnt_d = spawn_cnt_q;
      speed_cnt_d = speed_cnt_q;
      night_cnt_d = night_cnt_q;
      score_d     = score_q;
      speed_d     = speed_q;
      night_d     = night_q;
      y_sum       = '0;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (bus.start) begin
               state_d     = ST_RUN;
               dino_y_d    = '0;
               vel_d       = '0;
               obs_v_d     = '0;
               spawn_cnt_d = MIN_GAP_C;
               speed_cnt_d = '0;
               night_cnt_d = '0;
               score_d     = '0;
               speed_d     = SPEED_INIT_C;
               night_d     = 1'b0;
            end
         end

         ST_RUN: begin
            if (collide) begin
               state_d = ST_OVER;
            end else begin
               if (score_q != 16'hFFFF) begin
                  score_d = score_q + 16'd1;
               end

               if (speed_cnt_q == SPEED_STEP_C - 16'd1) begin
                  speed_cnt_d = '0;
                  if (speed_q < SPEED_MAX_C) begin
                     speed_d = speed_q + 1'b1;
                  end
               end else begin
                  speed_cnt_d = speed_cnt_q + 16'd1;
               end

               if (night_cnt_q == NIGHT_PER_C - 16'd1) begin
                  night_cnt_d = '0;
                  night_d     = ~night_q;
               end else begin
                  night_cnt_d = night_cnt_q + 16'd1;
               end

               // Grounded means both height and velocity are zero; the apex
               // frame has zero velocity but nonzero height.
               if ((dino_y_q == '0) && (vel_q == '0)) begin
                  if (bus.jump) begin
                     dino_y_d = JUMP_V_C;
                     vel_d    = VEL0_S;
                  end
               end else begin
                  y_sum = $signed({2'b00, dino_y_q}) + $signed({vel_q[VW-1], vel_q});
                  if (y_sum[SW-1] || (y_sum == '0)) begin
                     dino_y_d = '0;
                     vel_d    = '0;
                  end else begin
                     dino_y_d = y_sum[COORD_W-1:0];
                     vel_d    = vel_q - GRAV_S;
                  end
               end

               for (int i = 0; i < NUM_OBS; i++) begin
                  if (obs_v_q[i]) begin
                     if (obs_x_q[i] < speed_q) begin
                        obs_v_d[i] = 1'b0;
                     end else begin
                        obs_x_d[i] = obs_x_q[i] - speed_q;
                     end
                  end
               end

               // A due spawn with no free slot waits at zero.
               if (spawn_cnt_q == '0) begin
                  if (free_taken) begin
                     for (int i = 0; i < NUM_OBS; i++) begin
                        if (free_mask[i]) begin
                           obs_x_d[i] = SPAWN_X_C;
                           obs_v_d[i] = 1'b1;
                        end
                     end
                     spawn_cnt_d = MIN_GAP_C + (lfsr & GAP_MASK_C);
                  end
               end else begin
                  spawn_cnt_d = spawn_cnt_q - 16'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge game_clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         dino_y_q    <= '0;
         vel_q       <= '0;
         for (int i = 0; i < NUM_OBS; i++) begin
            obs_x_q[i] <= '0;
         end
         obs_v_q     <= '0;
         spawn_cnt_q <= '0;
         speed_cnt_q <= '0;
         night_cnt_q <= '0;
         score_q     <= '0;
         speed_q     <= SPEED_INIT_C;
         night_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         dino_y_q    <= dino_y_d;
         vel_q       <= vel_d;
         obs_x_q     <= obs_x_d;
         obs_v_q     <= obs_v_d;
         spawn_cnt_q <= spawn_cnt_d;
         speed_cnt_q <= speed_cnt_d;
         night_cnt_q <= night_cnt_d;
         score_q     <= score_d;
         speed_q     <= speed_d;
         night_q     <= night_d;
      end
   end

   for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs_out
      assign bus.obstacle_x[g*COORD_W +: COORD_W] = obs_x_q[g];
   end

   assign bus.dino_y         = dino_y_q;
   assign bus.obstacle_valid = obs_v_q;
   assign bus.night          = night_q;
   assign bus.game_over      = (state_q == ST_OVER);
   assign bus.score          = score_q;
   assign bus.speed          = speed_q;

endmodule
